// File: rtl/agnus_dma_slot_arbiter_pkg.sv
// Shared definitions for the Agnus chip-bus slot arbiter.
//   sel_e           : encoded bus owner as seen by the chip address mux
//   SLOT_*          : hpos[1:0] slot phase constants
//   GRANT_*         : one-hot grant bit positions, bit 7 = cpu
//   slot_elig_mask  : which owners may use the bus in a given slot phase
package agnus_dma_slot_arbiter_pkg;

  typedef enum logic [2:0] {
    SEL_CPU = 3'd0,
    SEL_DSK = 3'd1,
    SEL_REF = 3'd2,
    SEL_AUD = 3'd3,
    SEL_BPL = 3'd4,
    SEL_SPR = 3'd5,
    SEL_COP = 3'd6,
    SEL_BLT = 3'd7
  } sel_e;

  localparam logic [1:0] SLOT_CPU_ONLY = 2'd0;
  localparam logic [1:0] SLOT_ODD_A    = 2'd1;
  localparam logic [1:0] SLOT_BLT      = 2'd2;
  localparam logic [1:0] SLOT_ODD_B    = 2'd3;

  localparam int GRANT_DSK = 0;
  localparam int GRANT_REF = 1;
  localparam int GRANT_AUD = 2;
  localparam int GRANT_BPL = 3;
  localparam int GRANT_SPR = 4;
  localparam int GRANT_COP = 5;
  localparam int GRANT_BLT = 6;
  localparam int GRANT_CPU = 7;

  localparam logic [7:0] GRANT_CPU_ONEHOT = 8'h80;

  // Eligibility masks in grant bit order {cpu,blt,cop,spr,bpl,aud,ref,dsk}.
  // The CPU is eligible in every slot so the arbiter always has an owner.
  function automatic logic [7:0] slot_elig_mask(input logic [1:0] phase);
    logic [7:0] m;
    m = GRANT_CPU_ONEHOT;
    case (phase)
      SLOT_CPU_ONLY: m = 8'b1000_0000;
      SLOT_ODD_A:    m = 8'b1110_1011;  // dsk ref bpl cop blt cpu
      SLOT_BLT:      m = 8'b1100_0000;  // blt cpu
      SLOT_ODD_B:    m = 8'b1001_1111;  // dsk ref aud bpl spr cpu
      default:       m = GRANT_CPU_ONEHOT;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/agnus_bls_throttle.sv
// Blitter-slowdown throttle. Counts consecutive even slots in which the CPU
// is still waiting for the bus; once the count saturates the blitter is held
// off so the CPU gets through.
//   clk, reset   : clock, synchronous active-high reset
//   clk7_en      : bus-slot enable, state moves only when high
//   even_slot    : current slot has hpos[0]==0
//   bls          : CPU waiting for the chip bus
//   bltpri       : nasty mode, throttle disabled
//   blocked      : registered saturation flag
//   blocked_next : saturation flag for the count being written this edge
module agnus_bls_throttle
  import agnus_dma_slot_arbiter_pkg::*;
#(
  parameter int BLS_CNT_MAX = 3,
  parameter int CNT_W       = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clk7_en,
  input  logic even_slot,
  input  logic bls,
  input  logic bltpri,
  output logic blocked,
  output logic blocked_next
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLS_CNT_MAX);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt;
    if (clk7_en && even_slot) begin
      if (bltpri || !bls) begin
        cnt_next = '0;
      end else if (cnt < CNT_MAX) begin
        cnt_next = cnt + CNT_W'(1);
      end
    end
  end

  // The arbiter uses the next-count view so that saturation blocks the
  // blitter on the very edge the counter reaches its limit.
  assign blocked_next = (cnt_next == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      blocked <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      blocked <= blocked_next;
    end
  end

endmodule

// File: rtl/agnus_dma_slot_arbiter.sv
// Registered chip-bus slot arbiter. Each clk7 slot picks one bus owner from
// disk, refresh, audio, bitplane, sprite, copper, blitter and CPU using slot
// eligibility plus fixed priority, and drives the Gary/RAM strobes.
//   clk, reset         : clock, synchronous active-high reset
//   clk7_en            : bus-slot enable
//   hpos               : beam counter, hpos[1:0] is the slot phase
//   req_*              : DMA requests (spr/cop/blt already gated by DMACON)
//   wr_dsk, we_blt     : disk / blitter slot is a write
//   bls, bltpri        : CPU waiting, blitter nasty mode
//   grant              : one-hot owner {cpu,blt,cop,spr,bpl,aud,ref,dsk}
//   sel                : encoded owner for the address mux
//   dbr, dbwe          : Agnus owns data bus, DMA write cycle
//   cpu_custom         : CPU owns this slot
//   blt_blocked        : blitter held off by the slowdown throttle
module agnus_dma_slot_arbiter
  import agnus_dma_slot_arbiter_pkg::*;
#(
  parameter int BLS_CNT_MAX = 3,
  parameter int CNT_W       = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk7_en,
  input  logic [8:0] hpos,
  input  logic       req_dsk,
  input  logic       wr_dsk,
  input  logic       req_ref,
  input  logic       req_aud,
  input  logic       req_bpl,
  input  logic       req_spr,
  input  logic       req_cop,
  input  logic       req_blt,
  input  logic       we_blt,
  input  logic       bls,
  input  logic       bltpri,
  output logic [7:0] grant,
  output logic [2:0] sel,
  output logic       dbr,
  output logic       dbwe,
  output logic       cpu_custom,
  output logic       blt_blocked
);

  logic [1:0] phase;
  logic       blocked_next;
  logic [7:0] req_vec;
  logic [7:0] cand;
  logic [7:0] win_grant;
  sel_e       win_sel;
  logic       win_dbwe;
  sel_e       sel_q;
  logic       unused_hpos;

  assign phase       = hpos[1:0];
  assign unused_hpos = ^hpos[8:2];

  agnus_bls_throttle #(
    .BLS_CNT_MAX (BLS_CNT_MAX),
    .CNT_W       (CNT_W)
  ) u_bls_throttle (
    .clk          (clk),
    .reset        (reset),
    .clk7_en      (clk7_en),
    .even_slot    (~hpos[0]),
    .bls          (bls),
    .bltpri       (bltpri),
    .blocked      (blt_blocked),
    .blocked_next (blocked_next)
  );

  // CPU bit is always set: it is the fallback owner.
  assign req_vec = {1'b1, req_blt & ~blocked_next, req_cop, req_spr,
                    req_bpl, req_aud, req_ref, req_dsk};
  assign cand    = req_vec & slot_elig_mask(phase);

  // Lowest set bit wins; scanning downward lets the highest priority
  // candidate overwrite anything found before it.
  always_comb begin
    win_grant = GRANT_CPU_ONEHOT;
    win_sel   = SEL_CPU;
    for (int i = GRANT_BLT; i >= GRANT_DSK; i--) begin
      if (cand[i]) begin
        win_grant = 8'(1) << i;
        win_sel   = sel_e'(3'(i + 1));
      end
    end
  end

  assign win_dbwe = ((win_sel == SEL_DSK) && wr_dsk) ||
                    ((win_sel == SEL_BLT) && we_blt);

  always_ff @(posedge clk) begin
    if (reset) begin
      grant <= GRANT_CPU_ONEHOT;
      sel_q <= SEL_CPU;
      dbwe  <= 1'b0;
    end else if (clk7_en) begin
      grant <= win_grant;
      sel_q <= win_sel;
      dbwe  <= win_dbwe;
    end
  end

  assign sel        = sel_q;
  assign dbr        = (sel_q != SEL_CPU);
  assign cpu_custom = (sel_q == SEL_CPU);

endmodule

// File: tb/tb_agnus_dma_slot_arbiter.sv
module tb_agnus_dma_slot_arbiter;

  localparam int BLS_MAX = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clk7_en = 1'b0;
  logic [8:0] hpos = '0;
  logic       req_dsk = 0, wr_dsk = 0, req_ref = 0, req_aud = 0, req_bpl = 0;
  logic       req_spr = 0, req_cop = 0, req_blt = 0, we_blt = 0;
  logic       bls = 0, bltpri = 0;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       dbr, dbwe, cpu_custom, blt_blocked;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  agnus_dma_slot_arbiter #(.BLS_CNT_MAX(BLS_MAX), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .clk7_en(clk7_en), .hpos(hpos),
    .req_dsk(req_dsk), .wr_dsk(wr_dsk), .req_ref(req_ref), .req_aud(req_aud),
    .req_bpl(req_bpl), .req_spr(req_spr), .req_cop(req_cop), .req_blt(req_blt),
    .we_blt(we_blt), .bls(bls), .bltpri(bltpri),
    .grant(grant), .sel(sel), .dbr(dbr), .dbwe(dbwe),
    .cpu_custom(cpu_custom), .blt_blocked(blt_blocked)
  );

  // Reference model: owner codes 0 cpu,1 dsk,...,7 blt; priority is simply
  // ascending code from 1 to 7, with cpu as fallback.
  int         m_cnt = 0;
  bit         m_blk = 0;
  int         m_sel = 0;
  logic [7:0] m_grant = 8'h80;
  bit         m_dbwe = 0;

  // Eligible owner codes per phase, bit n = owner code n.
  function automatic logic [7:0] elig_codes(input int ph);
    case (ph)
      0:       return 8'b0000_0001;               // cpu
      1:       return 8'b1101_0111;               // cpu dsk ref bpl cop blt
      2:       return 8'b1000_0001;               // cpu blt
      default: return 8'b0011_1111;               // cpu dsk ref aud bpl spr
    endcase
  endfunction

  function automatic bit requested(input int code);
    case (code)
      1: return req_dsk;
      2: return req_ref;
      3: return req_aud;
      4: return req_bpl;
      5: return req_spr;
      6: return req_cop;
      7: return req_blt;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_step(input bit en, input bit rst);
    logic [7:0] el;
    int         w;
    if (rst) begin
      m_cnt = 0; m_blk = 0; m_sel = 0; m_grant = 8'h80; m_dbwe = 0;
    end else if (en) begin
      if (hpos[0] == 1'b0) begin
        if (bltpri || !bls) m_cnt = 0;
        else if (m_cnt < BLS_MAX) m_cnt = m_cnt + 1;
      end
      m_blk = (m_cnt == BLS_MAX);
      el = elig_codes(int'(hpos[1:0]));
      w = 0;
      for (int c = 7; c >= 1; c--)
        if (el[c] && requested(c) && !(c == 7 && m_blk)) w = c;
      m_sel   = w;
      m_grant = (w == 0) ? 8'h80 : (8'h01 << (w - 1));
      m_dbwe  = (w == 1 && wr_dsk) || (w == 7 && we_blt);
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic compare_model();
    check("sel",         {5'd0, sel},         8'(m_sel));
    check("grant",       grant,               m_grant);
    check("dbr",         {7'd0, dbr},         {7'd0, (m_sel != 0)});
    check("dbwe",        {7'd0, dbwe},        {7'd0, m_dbwe});
    check("cpu_custom",  {7'd0, cpu_custom},  {7'd0, (m_sel == 0)});
    check("blt_blocked", {7'd0, blt_blocked}, {7'd0, m_blk});
  endtask

  // Inputs are set by the caller; model sees them, edge happens, compare.
  task automatic step(input bit en, input bit rst);
    @(negedge clk);
    clk7_en = en;
    reset   = rst;
    model_step(en, rst);
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic set_reqs(input logic [6:0] r);
    {req_blt, req_cop, req_spr, req_bpl, req_aud, req_ref, req_dsk} = r;
  endtask

  typedef struct {
    logic [1:0] ph;
    logic [6:0] req;     // {blt,cop,spr,bpl,aud,ref,dsk}
    logic       wr_dsk;
    logic       we_blt;
    logic [2:0] sel;
    logic [7:0] grant;
    logic       dbwe;
  } vec_t;

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{2'd0, 7'h7F, 1'b1, 1'b1, 3'd0, 8'h80, 1'b0};
    tbl[1]  = '{2'd1, 7'h7F, 1'b1, 1'b1, 3'd1, 8'h01, 1'b1};
    tbl[2]  = '{2'd2, 7'h7F, 1'b1, 1'b1, 3'd7, 8'h40, 1'b1};
    tbl[3]  = '{2'd3, 7'h7F, 1'b1, 1'b1, 3'd1, 8'h01, 1'b1};
    tbl[4]  = '{2'd1, 7'h10, 1'b0, 1'b0, 3'd0, 8'h80, 1'b0};
    tbl[5]  = '{2'd3, 7'h10, 1'b0, 1'b0, 3'd5, 8'h10, 1'b0};
    tbl[6]  = '{2'd1, 7'h34, 1'b0, 1'b0, 3'd6, 8'h20, 1'b0};
    tbl[7]  = '{2'd3, 7'h34, 1'b0, 1'b0, 3'd3, 8'h04, 1'b0};
    tbl[8]  = '{2'd1, 7'h68, 1'b0, 1'b1, 3'd4, 8'h08, 1'b0};
    tbl[9]  = '{2'd1, 7'h60, 1'b0, 1'b1, 3'd6, 8'h20, 1'b0};
    tbl[10] = '{2'd2, 7'h40, 1'b0, 1'b0, 3'd7, 8'h40, 1'b0};
    tbl[11] = '{2'd3, 7'h0A, 1'b0, 1'b0, 3'd2, 8'h02, 1'b0};
    tbl[12] = '{2'd3, 7'h01, 1'b0, 1'b0, 3'd1, 8'h01, 1'b0};
    tbl[13] = '{2'd2, 7'h00, 1'b0, 1'b0, 3'd0, 8'h80, 1'b0};

    // Reset state.
    step(1'b0, 1'b1);
    check("rst_grant", grant, 8'h80);
    check("rst_cpu_custom", {7'd0, cpu_custom}, 8'd1);

    // Single-slot vectors with the throttle idle.
    bls = 0; bltpri = 0;
    for (int i = 0; i < 14; i++) begin
      set_reqs(tbl[i].req);
      wr_dsk = tbl[i].wr_dsk;
      we_blt = tbl[i].we_blt;
      hpos   = {7'($urandom), tbl[i].ph};
      step(1'b1, 1'b0);
      check("tbl_sel",   {5'd0, sel}, {5'd0, tbl[i].sel});
      check("tbl_grant", grant, tbl[i].grant);
      check("tbl_dbwe",  {7'd0, dbwe}, {7'd0, tbl[i].dbwe});
    end

    // Throttle saturation, release on bls drop, bltpri mid-block.
    step(1'b0, 1'b1);
    set_reqs(7'h40); we_blt = 1; wr_dsk = 0; bls = 1; bltpri = 0;
    for (int s = 0; s <= 6; s++) begin
      hpos = 9'(s);
      step(1'b1, 1'b0);
      if (s == 1) check("bls_sel_before_block", {5'd0, sel}, 8'd7);
      if (s == 2) check("bls_not_yet_blocked", {7'd0, blt_blocked}, 8'd0);
      if (s == 4) check("bls_blocked_3rd_even", {7'd0, blt_blocked}, 8'd1);
      if (s >= 5) check("bls_blocked_sel", {5'd0, sel}, 8'd0);
    end
    bls = 0;
    hpos = 9'd7;  step(1'b1, 1'b0);
    check("bls_odd_holds", {7'd0, blt_blocked}, 8'd1);
    hpos = 9'd8;  step(1'b1, 1'b0);
    check("bls_release", {7'd0, blt_blocked}, 8'd0);
    hpos = 9'd9;  step(1'b1, 1'b0);
    check("bls_release_sel", {5'd0, sel}, 8'd7);
    bls = 1;
    for (int s = 10; s <= 15; s++) begin
      hpos = 9'(s);
      step(1'b1, 1'b0);
      if (s == 14) check("same_edge_block_sel", {5'd0, sel}, 8'd0);
    end
    bltpri = 1;
    hpos = 9'd17; step(1'b1, 1'b0);
    check("bltpri_odd_still_blocked", {5'd0, sel}, 8'd0);
    hpos = 9'd18; step(1'b1, 1'b0);
    check("bltpri_unblock_sel", {5'd0, sel}, 8'd7);
    check("bltpri_unblock_flag", {7'd0, blt_blocked}, 8'd0);

    // Nasty mode: throttle never engages.
    step(1'b0, 1'b1);
    bls = 1; bltpri = 1;
    for (int s = 0; s < 8; s++) begin
      hpos = 9'(s);
      step(1'b1, 1'b0);
      if (s[1:0] == 2'd1 || s[1:0] == 2'd2) begin
        check("nasty_sel", {5'd0, sel}, 8'd7);
        check("nasty_dbwe", {7'd0, dbwe}, 8'd1);
      end
    end

    // Disk write, then hold with clk7_en low while inputs change.
    bls = 0; bltpri = 0;
    set_reqs(7'h01); wr_dsk = 1; we_blt = 0;
    hpos = 9'd1; step(1'b1, 1'b0);
    check("dsk_sel", {5'd0, sel}, 8'd1);
    check("dsk_dbwe", {7'd0, dbwe}, 8'd1);
    set_reqs(7'h40); wr_dsk = 0; hpos = 9'd2;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0);
      check("hold_sel", {5'd0, sel}, 8'd1);
      check("hold_dbwe", {7'd0, dbwe}, 8'd1);
    end

    // Reset while blitter owns the bus, counter part-way up.
    step(1'b0, 1'b1);
    set_reqs(7'h40); we_blt = 1; bls = 1;
    for (int s = 0; s <= 2; s++) begin
      hpos = 9'(s);
      step(1'b1, 1'b0);
    end
    check("pre_reset_sel", {5'd0, sel}, 8'd7);
    step(1'b0, 1'b1);
    check("mid_reset_grant", grant, 8'h80);
    check("mid_reset_dbr", {7'd0, dbr}, 8'd0);
    check("mid_reset_dbwe", {7'd0, dbwe}, 8'd0);
    // Counter must restart from zero: two more even slots must not block.
    for (int s = 0; s <= 3; s++) begin
      hpos = 9'(s);
      step(1'b1, 1'b0);
    end
    check("post_reset_unblocked", {7'd0, blt_blocked}, 8'd0);

    // Randomized traffic against the model.
    hpos = '0;
    for (int n = 0; n < 1500; n++) begin
      bit en, rst;
      en  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 199) == 0);
      set_reqs(7'($urandom));
      wr_dsk = 1'($urandom);
      we_blt = 1'($urandom);
      if ($urandom_range(0, 9) == 0) bls = ~bls;
      bltpri = ($urandom_range(0, 19) == 0);
      step(en, rst);
      if (en && !rst) hpos = hpos + 9'd1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
